// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, FSM state encoding, frame sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Parity selection codes used by the PARITY parameter of TX and RX.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Frame-level states; RX walks the same sequence.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Number of bit periods in one frame: start + data + optional parity + stops.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLK_DIV-1 while enabled, pulses tick on the last count.
// Latency: tick is combinational from the counter; first tick CLK_DIV-1 cycles after en rises.
// Backpressure: none; clearing en parks the counter at 0.
module uart_baud_tick #(
    parameter int CLK_DIV = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("uart_baud_tick: CLK_DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);
    assign tick   = en && w_wrap;

    // Free-running bit-period counter, held at zero whenever the line is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data bits, parity and stop bits, baud from system clock.
// Latency: data_rdy high at edge N gives fetch=1 and start bit on out from edge N; frame is F cycles.
// Backpressure: pulls one word per frame via fetch; data_rdy only looked at in IDLE or last stop cycle.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_rdy,
    input  logic [DATA_BITS-1:0] data,
    output logic                 out,
    output logic                 fetch,
    output logic                 busy
);

    localparam int               BIT_W      = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY != PAR_NONE);
    localparam bit               ODD_PARITY = (PARITY == PAR_ODD);
    localparam logic             LAST_STOP  = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be in 5..9");
        end
        if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (frame_bits(DATA_BITS, PARITY, STOP_BITS) > 13) begin : g_bad_frame
            $error("uart_tx_cfg: frame longer than 13 bits");
        end
    endgenerate

    // Parity is fixed at capture so the payload register can be shifted freely afterwards.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return ODD_PARITY ? ~(^d) : (^d);
    endfunction

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [BIT_W-1:0]     w_bit_idx_nxt;
    logic                 r_stop_idx;
    logic                 w_stop_idx_nxt;
    logic                 r_out;
    logic                 w_out_nxt;
    logic                 r_fetch;
    logic                 w_fetch_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 w_capture;
    logic                 w_tick;
    logic                 w_baud_en;

    // Bit timing runs only while a frame is on the line; the capture edge starts it from 0.
    assign w_baud_en = (r_state != ST_IDLE);

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_baud_en),
        .tick  (w_tick)
    );

    assign out   = r_out;
    assign fetch = r_fetch;
    assign busy  = r_busy;

    // Next-state and next-output decode; outputs are registered from the next state so
    // the start bit and fetch appear on the capture edge itself.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_capture      = 1'b0;
        w_out_nxt      = 1'b1;
        w_fetch_nxt    = 1'b0;
        w_busy_nxt     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (data_rdy) begin
                    w_capture = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_bit_idx_nxt  = '0;
                        w_stop_idx_nxt = 1'b0;
                        w_state_nxt    = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt    = ST_STOP;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop_idx == LAST_STOP) begin
                        // Back-to-back: the next word is taken on the last stop-bit edge.
                        if (data_rdy) begin
                            w_capture = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_capture) begin
            w_state_nxt    = ST_START;
            w_shift_nxt    = data;
            w_par_nxt      = parity_of(data);
            w_bit_idx_nxt  = '0;
            w_stop_idx_nxt = 1'b0;
        end

        w_fetch_nxt = w_capture;
        w_busy_nxt  = (w_state_nxt != ST_IDLE);

        case (w_state_nxt)
            ST_START:  w_out_nxt = 1'b0;
            ST_DATA:   w_out_nxt = w_shift_nxt[0];
            ST_PARITY: w_out_nxt = w_par_nxt;
            default:   w_out_nxt = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line high immediately and drops the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_out      <= 1'b1;
            r_fetch    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_out      <= w_out_nxt;
            r_fetch    <= w_fetch_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five frame formats share one FIFO model, scoreboard and line monitor.
// Latency: expected line waveform is rebuilt per frame from the word and format rules.
// Backpressure: FIFO model raises data_rdy while non-empty and pops on each fetch pulse.
module tb_uart_tx_cfg;

    // Format table per DUT instance: clocks/bit, data bits, parity, stop bits.
    localparam int CD [5] = '{4, 4, 4, 4, 2};
    localparam int DB [5] = '{8, 8, 8, 5, 9};
    localparam int PR [5] = '{0, 2, 1, 0, 1};
    localparam int SB [5] = '{1, 2, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tb_rdy;
    logic [8:0] tb_data;
    logic [4:0] rdy_v;
    logic [4:0] out_v;
    logic [4:0] fetch_v;
    logic [4:0] busy_v;
    int         sel;
    logic       w_out;
    logic       w_fetch;
    logic       w_busy;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    bit  fifo_mode;
    int  fifo [$];
    int  exp_q [$];
    int  fetch_cyc [$];
    int  busy_cycles;

    bit  exp_line [$];
    bit  act_line [$];
    bit  last_line [$];
    bit  in_frame = 1'b0;
    int  pos;
    int  mism;
    int  first_bad;
    int  cur_word;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < 5; k++) rdy_v[k] = tb_rdy && (sel == k);
        w_out   = out_v[sel];
        w_fetch = fetch_v[sel];
        w_busy  = busy_v[sel];
    end

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_rdy(rdy_v[0]), .data(tb_data[7:0]),
        .out(out_v[0]), .fetch(fetch_v[0]), .busy(busy_v[0]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_rdy(rdy_v[1]), .data(tb_data[7:0]),
        .out(out_v[1]), .fetch(fetch_v[1]), .busy(busy_v[1]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data_rdy(rdy_v[2]), .data(tb_data[7:0]),
        .out(out_v[2]), .fetch(fetch_v[2]), .busy(busy_v[2]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .data_rdy(rdy_v[3]), .data(tb_data[4:0]),
        .out(out_v[3]), .fetch(fetch_v[3]), .busy(busy_v[3]));
    uart_tx_cfg #(.CLK_DIV(2), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .data_rdy(rdy_v[4]), .data(tb_data[8:0]),
        .out(out_v[4]), .fetch(fetch_v[4]), .busy(busy_v[4]));

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference waveform: list the frame bits from the format rules, then stretch each bit.
    function automatic void build_line(input int w);
        bit bits [$];
        int ones = 0;
        exp_line.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < DB[sel]; i++) begin
            bits.push_back(bit'((w >> i) & 1));
            ones += (w >> i) & 1;
        end
        if (PR[sel] == 1) bits.push_back(bit'((ones + 1) % 2));
        if (PR[sel] == 2) bits.push_back(bit'(ones % 2));
        for (int s = 0; s < SB[sel]; s++) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c < CD[sel]; c++) exp_line.push_back(bits[b]);
        end
    endfunction

    // FIFO model: offer head word while non-empty, pop on each fetch pulse.
    always @(negedge clk) begin
        if (fifo_mode) begin
            if (w_fetch && fifo.size() > 0) void'(fifo.pop_front());
            tb_rdy  = (fifo.size() > 0);
            tb_data = (fifo.size() > 0) ? fifo[0][8:0] : 9'd0;
        end
    end

    // Monitor: on fetch pop the scoreboard, follow the line for a whole frame, then decode it
    // like a receiver sampling mid-bit.
    always @(negedge clk) begin
        if (w_busy) busy_cycles++;
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (w_fetch) begin
                    fetch_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_fetch", 1, 0);
                    end else begin
                        cur_word  = exp_q.pop_front();
                        build_line(cur_word);
                        in_frame  = 1'b1;
                        pos       = 0;
                        mism      = 0;
                        first_bad = -1;
                        act_line.delete();
                    end
                end else begin
                    check(w_out && !w_busy, "idle_line", {w_busy, w_out}, 1);
                end
            end
            if (in_frame) begin
                act_line.push_back(w_out);
                if (w_out !== exp_line[pos] || w_busy !== 1'b1 || w_fetch !== (pos == 0)) begin
                    mism++;
                    if (first_bad < 0) first_bad = pos;
                end
                pos++;
                if (pos == exp_line.size()) begin
                    int cd;
                    int dec;
                    int ones;
                    bit fmt_ok;
                    check(mism == 0, "frame_line_mismatches", mism, 0);
                    if (mism != 0) $display("  first bad cycle in frame: %0d", first_bad);
                    cd     = CD[sel];
                    dec    = 0;
                    ones   = 0;
                    fmt_ok = (act_line[cd / 2] == 1'b0);
                    for (int i = 0; i < DB[sel]; i++) begin
                        if (act_line[(1 + i) * cd + cd / 2]) begin
                            dec |= (1 << i);
                            ones++;
                        end
                    end
                    if (PR[sel] != 0) begin
                        ones += int'(act_line[(1 + DB[sel]) * cd + cd / 2]);
                        if (PR[sel] == 1 && (ones % 2) != 1) fmt_ok = 1'b0;
                        if (PR[sel] == 2 && (ones % 2) != 0) fmt_ok = 1'b0;
                    end
                    for (int s = 0; s < SB[sel]; s++) begin
                        if (!act_line[(1 + DB[sel] + (PR[sel] != 0) + s) * cd + cd / 2]) fmt_ok = 1'b0;
                    end
                    check(fmt_ok, "rx_format", int'(fmt_ok), 1);
                    check(dec == cur_word, "rx_word", dec, cur_word);
                    last_line = act_line;
                    in_frame  = 1'b0;
                end
            end
        end
    end

    task automatic push_word(input int w);
        int m;
        m = w & ((1 << DB[sel]) - 1);
        fifo.push_back(m);
        exp_q.push_back(m);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        @(negedge clk); #1;
        while ((fifo.size() != 0 || exp_q.size() != 0 || in_frame || w_busy) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(n < budget, name, n, budget);
    endtask

    task automatic wait_fetches(input int count, input int budget, input string name);
        int n = 0;
        while (fetch_cyc.size() < count && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(n < budget, name, fetch_cyc.size(), count);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        tb_rdy    = 1'b0;
        tb_data   = '0;
        sel       = 0;
        fifo_mode = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check(out_v[k] && !busy_v[k] && !fetch_v[k], "reset_outputs",
                  {29'd0, fetch_v[k], busy_v[k], out_v[k]}, 1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // 8N1, single 0xA5: one fetch, 40 busy cycles.
        fetch_cyc.delete();
        busy_cycles = 0;
        push_word(8'hA5);
        wait_idle(200, "t1_timeout");
        check(fetch_cyc.size() == 1, "t1_fetch_count", fetch_cyc.size(), 1);
        check(busy_cycles == 40, "t1_busy_cycles", busy_cycles, 40);

        // 8E2 with 0x03: parity 0 then 8 high stop cycles.
        sel = 1; #1;
        push_word(8'h03);
        wait_idle(200, "t2e_timeout");
        check(last_line[38] == 1'b0, "t2e_parity_bit", int'(last_line[38]), 0);
        t = 0;
        for (int i = last_line.size() - 1; i >= 0 && last_line[i]; i--) t++;
        check(t == 8, "t2e_stop_high_cycles", t, 8);

        // 8O1 with 0x03: parity 1.
        sel = 2; #1;
        push_word(8'h03);
        wait_idle(200, "t2o_timeout");
        check(last_line[38] == 1'b1, "t2o_parity_bit", int'(last_line[38]), 1);

        // 5N1 back-to-back from a preloaded FIFO: fetches exactly 28 cycles apart.
        sel = 3; #1;
        fetch_cyc.delete();
        push_word(5'h1F);
        push_word(5'h00);
        push_word(5'h15);
        wait_idle(300, "t3_timeout");
        check(fetch_cyc.size() == 3, "t3_fetch_count", fetch_cyc.size(), 3);
        if (fetch_cyc.size() == 3) begin
            check(fetch_cyc[1] - fetch_cyc[0] == 28, "t3_spacing_0", fetch_cyc[1] - fetch_cyc[0], 28);
            check(fetch_cyc[2] - fetch_cyc[1] == 28, "t3_spacing_1", fetch_cyc[2] - fetch_cyc[1], 28);
        end
        check(fifo.size() == 0, "t3_fifo_empty", fifo.size(), 0);

        // data_rdy pulsed mid-frame must be ignored.
        sel = 0; #1;
        fetch_cyc.delete();
        push_word(8'h3C);
        wait_fetches(1, 50, "t4_first_fetch");
        fifo_mode = 1'b0;
        repeat (10) @(negedge clk);
        tb_rdy  = 1'b1;
        tb_data = 9'h0FF;
        @(negedge clk);
        tb_rdy    = 1'b0;
        fifo_mode = 1'b1;
        wait_idle(200, "t4_timeout");
        repeat (10) @(negedge clk);
        #1;
        check(fetch_cyc.size() == 1, "t4_fetch_count", fetch_cyc.size(), 1);
        check(!w_busy && w_out, "t4_idle_after", {w_busy, w_out}, 1);

        // Asynchronous reset in cycle 15 of an 8N1 frame, then a clean 0x5A frame.
        fetch_cyc.delete();
        push_word(8'h00);
        wait_fetches(1, 50, "t5_first_fetch");
        repeat (15) @(posedge clk);
        #2;
        check(w_out == 1'b0, "t5_line_low_before_reset", int'(w_out), 0);
        rst_n = 1'b0;
        #1;
        check(w_out == 1'b1, "t5_async_out", int'(w_out), 1);
        check(w_busy == 1'b0, "t5_async_busy", int'(w_busy), 0);
        check(w_fetch == 1'b0, "t5_async_fetch", int'(w_fetch), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check(fetch_cyc.size() == 1, "t5_no_refetch", fetch_cyc.size(), 1);
        fetch_cyc.delete();
        push_word(8'h5A);
        wait_idle(200, "t5_timeout");
        check(fetch_cyc.size() == 1, "t5_new_frame_fetch", fetch_cyc.size(), 1);

        // CLK_DIV=2, 9O2: 1000 random words in bursts with random idle gaps.
        sel = 4; #1;
        fetch_cyc.delete();
        for (int b = 0; b < 50; b++) begin
            for (int i = 0; i < 20; i++) push_word(int'($urandom_range(0, 511)));
            wait_idle(20 * 26 + 100, "t6_timeout");
            repeat ($urandom_range(0, 5)) @(negedge clk);
            #1;
        end
        check(fetch_cyc.size() == 1000, "t6_fetch_count", fetch_cyc.size(), 1000);
        check(exp_q.size() == 0, "t6_scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
